// File: rtl/operand_fetch.sv
// Operand fetch stage: 32 x 32-bit register file with write-through read,
// one-cycle pipeline register toward execute, and a load-use interlock.
// Build option: define OPERAND_FETCH_INTERLOCK_EN to enable the hazard
// interlock; when undefined the hazard term is forced off and stall_o
// simply mirrors stall_i (software spaces dependent instructions).
module operand_fetch #(
    parameter int D_INFO_W = 8,
    parameter int WRSV     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                v_i,
    input  logic [31:0]         pc_i,
    input  logic [15:0]         imm_i,
    input  logic [4:0]          rs0_i,
    input  logic [4:0]          rs1_i,
    input  logic                use0_i,
    input  logic                use1_i,
    input  logic [4:0]          rd_i,
    input  logic [D_INFO_W-1:0] d_info_i,
    input  logic                wb_i,
    input  logic [4:0]          wb_r_i,
    input  logic [31:0]         wb_data_i,
    input  logic                flush_i,
    input  logic                stall_i,
    output logic                stall_o,
    output logic                v_o,
    output logic [31:0]         pc_o,
    output logic [15:0]         imm_o,
    output logic [4:0]          wb_r_o,
    output logic [D_INFO_W-1:0] d_info_o,
    output logic [31:0]         opr0_o,
    output logic [31:0]         opr1_o
);

    logic [31:0]         rf_q [32];
    logic [31:0]         rf_d [32];

    logic                v_q, v_d;
    logic [31:0]         pc_q, pc_d;
    logic [15:0]         imm_q, imm_d;
    logic [4:0]          wb_r_q, wb_r_d;
    logic [D_INFO_W-1:0] d_info_q, d_info_d;
    logic [31:0]         opr0_q, opr0_d;
    logic [31:0]         opr1_q, opr1_d;

    logic                dep0, dep1, hazard_raw, hazard;
    logic [31:0]         rd0, rd1;

    // Register file next state; reading rf_d gives write-through for free.
    always_comb begin
        rf_d = rf_q;
        if (wb_i) begin
            rf_d[wb_r_i] = wb_data_i;
        end
    end

    assign rd0 = rf_d[rs0_i];
    assign rd1 = rf_d[rs1_i];

    // Register file storage; writes happen regardless of stall/flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Instruction in decode reads the destination of the one sitting at our output.
    always_comb begin
        dep0       = use0_i && (rs0_i == wb_r_q);
        dep1       = use1_i && (rs1_i == wb_r_q);
        hazard_raw = v_i && v_q && d_info_q[WRSV] && (dep0 || dep1);
    end

`ifdef OPERAND_FETCH_INTERLOCK_EN
    assign hazard = hazard_raw;
`else
    // Interlock compiled out: the compare stays elaborated but is masked off.
    assign hazard = 1'b0 & hazard_raw;
`endif

    assign stall_o = stall_i || (hazard && !flush_i);

    // Pipeline register next state: stall > flush > hazard bubble > load.
    always_comb begin
        v_d      = v_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        wb_r_d   = wb_r_q;
        d_info_d = d_info_q;
        opr0_d   = opr0_q;
        opr1_d   = opr1_q;
        if (stall_i) begin
            v_d = v_q;
        end else if (flush_i) begin
            v_d = 1'b0;
        end else if (hazard) begin
            v_d = 1'b0;
        end else begin
            v_d      = v_i;
            pc_d     = pc_i;
            imm_d    = imm_i;
            wb_r_d   = rd_i;
            d_info_d = d_info_i;
            opr0_d   = rd0;
            opr1_d   = rd1;
        end
    end

    // Pipeline register state; reset drops any held or bubbled instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q      <= 1'b0;
            pc_q     <= '0;
            imm_q    <= '0;
            wb_r_q   <= '0;
            d_info_q <= '0;
            opr0_q   <= '0;
            opr1_q   <= '0;
        end else begin
            v_q      <= v_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            wb_r_q   <= wb_r_d;
            d_info_q <= d_info_d;
            opr0_q   <= opr0_d;
            opr1_q   <= opr1_d;
        end
    end

    assign v_o      = v_q;
    assign pc_o     = pc_q;
    assign imm_o    = imm_q;
    assign wb_r_o   = wb_r_q;
    assign d_info_o = d_info_q;
    assign opr0_o   = opr0_q;
    assign opr1_o   = opr1_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vectors against a behavioural model
// (register array + expected output record), plus literal spot checks.
module tb_operand_fetch;

    localparam int DW   = 8;
    localparam int WRSV = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          v_i = 1'b0;
    logic [31:0]   pc_i = '0;
    logic [15:0]   imm_i = '0;
    logic [4:0]    rs0_i = '0, rs1_i = '0, rd_i = '0, wb_r_i = '0;
    logic          use0_i = 1'b0, use1_i = 1'b0;
    logic [DW-1:0] d_info_i = '0;
    logic          wb_i = 1'b0;
    logic [31:0]   wb_data_i = '0;
    logic          flush_i = 1'b0, stall_i = 1'b0;
    logic          stall_o, v_o;
    logic [31:0]   pc_o, opr0_o, opr1_o;
    logic [15:0]   imm_o;
    logic [4:0]    wb_r_o;
    logic [DW-1:0] d_info_o;

    operand_fetch #(.D_INFO_W(DW), .WRSV(WRSV)) dut (
        .clk(clk), .reset(reset), .v_i(v_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs0_i(rs0_i), .rs1_i(rs1_i), .use0_i(use0_i), .use1_i(use1_i),
        .rd_i(rd_i), .d_info_i(d_info_i), .wb_i(wb_i), .wb_r_i(wb_r_i),
        .wb_data_i(wb_data_i), .flush_i(flush_i), .stall_i(stall_i),
        .stall_o(stall_o), .v_o(v_o), .pc_o(pc_o), .imm_o(imm_o),
        .wb_r_o(wb_r_o), .d_info_o(d_info_o), .opr0_o(opr0_o), .opr1_o(opr1_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model state
    logic [31:0]   regs [32];
    logic          m_v;
    logic [31:0]   m_pc, m_opr0, m_opr1;
    logic [15:0]   m_imm;
    logic [4:0]    m_wbr;
    logic [DW-1:0] m_dinfo;
    logic          last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) regs[i] = '0;
        m_v = 0; m_pc = '0; m_opr0 = '0; m_opr1 = '0; m_imm = '0; m_wbr = '0; m_dinfo = '0;
    endtask

    function automatic logic model_hazard();
`ifdef OPERAND_FETCH_INTERLOCK_EN
        return v_i && m_v && m_dinfo[WRSV] &&
               ((use0_i && rs0_i == m_wbr) || (use1_i && rs1_i == m_wbr));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (wb_i && wb_r_i == r) return wb_data_i;
        return regs[r];
    endfunction

    // One clock: check stall_o before the edge, advance the model, check outputs after.
    task automatic tick();
        logic          hz, n_v;
        logic [31:0]   n_pc, n_o0, n_o1;
        logic [15:0]   n_imm;
        logic [4:0]    n_wbr;
        logic [DW-1:0] n_di;
        #1;
        hz = model_hazard();
        chk("stall_o", {31'd0, stall_o}, {31'd0, stall_i || (hz && !flush_i)});
        last_stall = stall_o;
        n_v = m_v; n_pc = m_pc; n_o0 = m_opr0; n_o1 = m_opr1; n_imm = m_imm; n_wbr = m_wbr; n_di = m_dinfo;
        if (stall_i) begin
        end else if (flush_i || hz) begin
            n_v = 0;
        end else begin
            n_v = v_i; n_pc = pc_i; n_imm = imm_i; n_wbr = rd_i; n_di = d_info_i;
            n_o0 = model_read(rs0_i); n_o1 = model_read(rs1_i);
        end
        @(posedge clk);
        #1;
        if (wb_i) regs[wb_r_i] = wb_data_i;
        m_v = n_v; m_pc = n_pc; m_opr0 = n_o0; m_opr1 = n_o1; m_imm = n_imm; m_wbr = n_wbr; m_dinfo = n_di;
        chk("v_o", {31'd0, v_o}, {31'd0, m_v});
        if (m_v) begin
            chk("pc_o", pc_o, m_pc);
            chk("imm_o", {16'd0, imm_o}, {16'd0, m_imm});
            chk("wb_r_o", {27'd0, wb_r_o}, {27'd0, m_wbr});
            chk("d_info_o", {24'd0, d_info_o}, {24'd0, m_dinfo});
            chk("opr0_o", opr0_o, m_opr0);
            chk("opr1_o", opr1_o, m_opr1);
        end
    endtask

    task automatic instr(input logic v, input logic [31:0] pc, input logic [4:0] rs0, input logic u0,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic [DW-1:0] di);
        v_i = v; pc_i = pc; imm_i = pc[15:0] ^ 16'h5A5A; rs0_i = rs0; use0_i = u0;
        rs1_i = rs1; use1_i = u1; rd_i = rd; d_info_i = di;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_i = en; wb_r_i = r; wb_data_i = d;
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b0;
        #1;
        model_clear();
        chk("rst_v_o", {31'd0, v_o}, 32'd0);
        chk("rst_opr0_o", opr0_o, 32'd0);
        chk("rst_pc_o", pc_o, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        model_clear();
        #1;
        chk("init_v_o", {31'd0, v_o}, 32'd0);
        chk("init_pc_o", pc_o, 32'd0);
        chk("init_opr1_o", opr1_o, 32'd0);
        chk("init_dinfo_o", {24'd0, d_info_o}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;

        // write r3 then read it back
        wb(1, 5'd3, 32'h0000_00AA); instr(0, 32'h0, 5'd0, 0, 5'd0, 0, 5'd0, 8'h0); tick();
        wb(0, 5'd0, 32'h0); instr(1, 32'h100, 5'd3, 1, 5'd0, 0, 5'd9, 8'h0); tick();
        chk("r3_read", opr0_o, 32'h0000_00AA);
        chk("r3_v", {31'd0, v_o}, 32'd1);

        // same-cycle write-through
        wb(1, 5'd7, 32'h1234_5678); instr(1, 32'h104, 5'd0, 0, 5'd7, 1, 5'd9, 8'h0); tick();
        chk("wt_opr1", opr1_o, 32'h1234_5678);

        // r0 is an ordinary register
        wb(1, 5'd0, 32'hDEAD_BEEF); instr(0, 32'h0, 5'd0, 0, 5'd0, 0, 5'd0, 8'h0); tick();
        wb(0, 5'd0, 32'h0); instr(1, 32'h108, 5'd0, 1, 5'd0, 1, 5'd1, 8'h0); tick();
        chk("r0_ordinary", opr0_o, 32'hDEAD_BEEF);

        // load-use pair on r5
        instr(1, 32'h10C, 5'd3, 1, 5'd0, 0, 5'd5, 8'h1); tick();
        instr(1, 32'h110, 5'd5, 1, 5'd0, 0, 5'd6, 8'h0);
`ifdef OPERAND_FETCH_INTERLOCK_EN
        tick();
        chk("luse_stall", {31'd0, last_stall}, 32'd1);
        chk("luse_bubble", {31'd0, v_o}, 32'd0);
        wb(1, 5'd5, 32'h0000_0055); tick();
        chk("luse_stall2", {31'd0, last_stall}, 32'd0);
        chk("luse_pc", pc_o, 32'h110);
        chk("luse_opr0", opr0_o, 32'h0000_0055);
`else
        tick();
        chk("luse_nostall", {31'd0, last_stall}, 32'd0);
        chk("luse_pc", pc_o, 32'h110);
        chk("luse_v", {31'd0, v_o}, 32'd1);
`endif
        wb(0, 5'd0, 32'h0);

        // unused sources, invalid input, and non-writing producer never stall
        instr(1, 32'h120, 5'd0, 0, 5'd0, 0, 5'd6, 8'h1); tick();
        instr(1, 32'h124, 5'd6, 0, 5'd6, 0, 5'd8, 8'h1); tick();
        chk("nouse_stall", {31'd0, last_stall}, 32'd0);
        instr(0, 32'h128, 5'd8, 1, 5'd8, 1, 5'd9, 8'h0); tick();
        chk("inv_stall", {31'd0, last_stall}, 32'd0);
        instr(1, 32'h12C, 5'd0, 0, 5'd0, 0, 5'd8, 8'h0); tick();
        instr(1, 32'h130, 5'd8, 1, 5'd8, 1, 5'd9, 8'h0); tick();
        chk("nowr_stall", {31'd0, last_stall}, 32'd0);

        // hazard together with flush
        instr(1, 32'h140, 5'd0, 0, 5'd0, 0, 5'd10, 8'h1); tick();
        instr(1, 32'h144, 5'd0, 0, 5'd10, 1, 5'd11, 8'h0); flush_i = 1; tick();
        chk("flush_stall", {31'd0, last_stall}, 32'd0);
        chk("flush_v", {31'd0, v_o}, 32'd0);
        flush_i = 0;
        instr(1, 32'h148, 5'd7, 1, 5'd3, 1, 5'd12, 8'h0); tick();
        instr(1, 32'h14C, 5'd0, 0, 5'd0, 0, 5'd13, 8'h0); stall_i = 1; flush_i = 1; tick();
        chk("sf_v", {31'd0, v_o}, 32'd1);
        chk("sf_pc", pc_o, 32'h148);
        flush_i = 0;

        // 3-cycle stall with a register write landing underneath
        for (int i = 0; i < 3; i++) begin
            instr(1, 32'h150 + 32'(i * 4), 5'(i), 1, 5'd1, 1, 5'd14, 8'h0);
            wb(i == 1, 5'd12, 32'hCAFE_0012);
            tick();
            chk("stall_pc", pc_o, 32'h148);
            chk("stall_opr0", opr0_o, 32'h1234_5678);
            chk("stall_v", {31'd0, v_o}, 32'd1);
        end
        stall_i = 0; wb(0, 5'd0, 32'h0);
        instr(1, 32'h160, 5'd12, 1, 5'd5, 1, 5'd15, 8'h0); tick();
        chk("stall_wr_r12", opr0_o, 32'hCAFE_0012);

        // reset pulse during a stall clears pipeline and file
        stall_i = 1; tick();
        reset_pulse();
        stall_i = 0;
        instr(0, 32'h0, 5'd0, 0, 5'd0, 0, 5'd0, 8'h0); tick();
        chk("post_rst_v", {31'd0, v_o}, 32'd0);
        instr(1, 32'h170, 5'd3, 1, 5'd7, 1, 5'd1, 8'h0); tick();
        chk("post_rst_r3", opr0_o, 32'd0);
        chk("post_rst_r7", opr1_o, 32'd0);
        instr(1, 32'h174, 5'd12, 1, 5'd0, 1, 5'd1, 8'h0); tick();
        chk("post_rst_r12", opr0_o, 32'd0);

        // mixed writes and reads across the file
        for (int i = 0; i < 8; i++) begin
            wb(1, 5'((i * 5 + 1) % 32), 32'hC0DE_0000 + 32'(i));
            instr(1, 32'h200 + 32'(i * 4), 5'(((i - 1) * 5 + 1) % 32), 1, 5'((i * 5 + 1) % 32), 1,
                  5'(i + 20), 8'(i));
            tick();
        end
        wb(0, 5'd0, 32'h0);
        instr(0, 32'h0, 5'd0, 0, 5'd0, 0, 5'd0, 8'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
